duart_chan_cmd_ctrl: RTL and testbench
======================================

// Module: duart_chan_cmd_ctrl
// PURPOSE
//  Command sequencer for one DUART channel. Decodes command-register (CRA) writes
//  into timed reset pulses, Tx/Rx enables, the MR1/MR2 pointer and break control.
//  Sits between the CPU bus decode and the channel datapath (SRA status, Tx/Rx engines).
//  Serialises multi-cycle commands with a one-deep pending slot.
// PARAMETERS
//  RST_PULSE_CYCLES  4   low time of RxReset_n/TxReset_n/ErrReset_n, cycles (>=1)
// PORTS
//  clk          in   1  system clock; all state on rising edge
//  reset_n      in   1  async active-low reset
//  data         in   8  CPU write data; [6:4]=misc cmd, [3]=TxDis, [2]=TxEn, [1]=RxDis, [0]=RxEn
//  cra_cs       in   1  command register select
//  r_w          in   1  1=read, 0=write; command accepted when cra_cs&!r_w
//  mr_wr        in   1  1-cycle pulse: CPU wrote MRxA; advances pointer
//  TxEMT        in   1  transmitter shift register and holding register empty
//  TxEN         out  1  transmitter enable
//  RxEN         out  1  receiver enable
//  RxReset_n    out  1  receiver reset, active low
//  TxReset_n    out  1  transmitter reset, active low
//  ErrReset_n   out  1  error-status reset, active low
//  mr_ptr       out  1  0=MR1 selected, 1=MR2
//  BreakOut     out  1  force TxD low
//  brk_chg_clr  out  1  1-cycle pulse: clear break-change interrupt
//  busy         out  1  FSM not in IDLE/BRK_ON, or pending slot full
//  cmd_ovf      out  1  1-cycle pulse: command dropped
// BEHAVIOUR
//  Reset: TxEN=0 RxEN=0 RxReset_n=1 TxReset_n=1 ErrReset_n=1 mr_ptr=0 BreakOut=0
//   brk_chg_clr=0 busy=0 cmd_ovf=0; FSM=IDLE; pending empty; pulse counter=0.
//  Enable bits apply the cycle after accept, any FSM state. Disable beats enable when both set.
//  Misc cmd 000: none. 001: mr_ptr<=0 next cycle. 101: brk_chg_clr pulse next cycle.
//   001/101 never enter FSM or pending slot.
//  mr_wr: mr_ptr<=1; stays 1 until cmd 001. mr_wr and cmd 001 together: cmd 001 wins.
//  FSM-routed cmds: 010 RxRst, 011 TxRst, 100 ErrRst, 110 BrkStart, 111 BrkStop.
//   IDLE or BRK_ON: cmd starts next cycle.
//   Other states: cmd goes to pending slot; pending full -> cmd dropped, cmd_ovf pulses.
//   Pending slot issues on the cycle FSM returns to IDLE/BRK_ON.
//  RX_RST: RxReset_n=0 for RST_PULSE_CYCLES; RxEN forced 0 on entry -> IDLE.
//  TX_RST: TxReset_n=0 for RST_PULSE_CYCLES; TxEN=0; BreakOut=0 on entry -> IDLE.
//  ERR_RST: ErrReset_n=0 for RST_PULSE_CYCLES -> previous resting state (IDLE or BRK_ON).
//  BrkStart: TxEN=0 -> ignored (stay IDLE). Else BRK_WAIT until TxEMT=1;
//   BreakOut=1 the cycle after TxEMT sampled high -> BRK_ON.
//  BrkStop in BRK_WAIT/BRK_ON: BreakOut=0 next cycle -> IDLE. In IDLE: no-op.
//  BrkStart in BRK_ON: no-op.
//  Same-write enable/misc: enables apply first. TxEn+BrkStart in one write proceeds to BRK_WAIT.
//  Pulse counter: RST_PULSE_CYCLES-1 down to 0; exit when 0. Width $clog2(RST_PULSE_CYCLES)+1.
//  reset_n low at any time: all outputs to reset values immediately; pulses end mid-flight.
// CONFIGURATION
//  DUART_BREAK_CTRL_EN defined: break FSM states and BreakOut as above.
//  Not defined: cmds 110/111 treated as 000 (no FSM entry, no pending use).
//   BreakOut tied 0; BRK_WAIT/BRK_ON not built.
// TESTING
//  1 Write 0x05 -> TxEN=1, RxEN=1 next cycle; write 0x0A -> both 0; write 0x0C -> TxEN=0.
//  2 Write 0x20 -> RxReset_n low exactly 4 cycles, RxEN=0, busy=1 throughout.
//    Write 0x30 during it -> TxReset_n low 4 cycles after; write 0x40 then -> cmd_ovf pulse.
//  3 TxEN=1, TxEMT=0, write 0x60 -> BreakOut stays 0. Raise TxEMT -> BreakOut=1 next cycle.
//    Write 0x70 -> BreakOut=0, state IDLE.
//  4 mr_wr pulse -> mr_ptr=1; write 0x10 with mr_wr same cycle -> mr_ptr=0.
//    Write 0x50 -> brk_chg_clr single-cycle pulse.
//  5 Assert reset_n=0 in cycle 2 of TX_RST -> TxReset_n=1, busy=0, all outputs reset immediately.
//  6 Build without DUART_BREAK_CTRL_EN: write 0x64 -> TxEN=1, BreakOut=0, busy stays 0.

Source files
------------

// File: rtl/duart_chan_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// duart_chan_cmd_ctrl_if
// CPU-side command bus for one DUART channel's command sequencer.
//   data    8  CPU write data; [6:4]=misc cmd, [3]=TxDis, [2]=TxEn, [1]=RxDis, [0]=RxEn
//   cra_cs  1  command register select
//   r_w     1  1=read, 0=write; a command is accepted when cra_cs & !r_w
//   mr_wr   1  one-cycle pulse: CPU wrote MRxA, advances the MR pointer
// master = bus decode side (drives), slave = command sequencer (receives).
// -----------------------------------------------------------------------------
interface duart_chan_cmd_ctrl_if;
    logic [7:0] data;
    logic       cra_cs;
    logic       r_w;
    logic       mr_wr;

    modport master (output data, cra_cs, r_w, mr_wr);
    modport slave  (input  data, cra_cs, r_w, mr_wr);
endinterface

// File: rtl/duart_chan_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// duart_chan_cmd_ctrl
// Command sequencer for one DUART channel. Decodes CRA writes into timed,
// active-low reset pulses, Tx/Rx enables, the MR1/MR2 pointer and break
// control. Multi-cycle commands are serialised with a one-deep pending slot.
//
// Optional feature: define DUART_BREAK_CTRL_EN to build the break states
// (BRK_WAIT/BRK_ON) and drive BreakOut. Without it, misc cmds 110/111 are
// treated as "no command" and BreakOut is tied low.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          CPU command bus (slave modport): data, cra_cs, r_w, mr_wr
//   TxEMT        transmitter shift and holding registers empty
//   TxEN, RxEN   transmitter / receiver enables
//   RxReset_n    receiver reset pulse, active low
//   TxReset_n    transmitter reset pulse, active low
//   ErrReset_n   error-status reset pulse, active low
//   mr_ptr       0 = MR1 selected, 1 = MR2
//   BreakOut     force TxD low
//   brk_chg_clr  one-cycle pulse: clear break-change interrupt
//   busy         sequencer not resting (IDLE/BRK_ON) or pending slot full
//   cmd_ovf      one-cycle pulse: command dropped (pending slot full)
// -----------------------------------------------------------------------------
module duart_chan_cmd_ctrl #(
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    duart_chan_cmd_ctrl_if.slave        bus,
    input  logic                        TxEMT,
    output logic                        TxEN,
    output logic                        RxEN,
    output logic                        RxReset_n,
    output logic                        TxReset_n,
    output logic                        ErrReset_n,
    output logic                        mr_ptr,
    output logic                        BreakOut,
    output logic                        brk_chg_clr,
    output logic                        busy,
    output logic                        cmd_ovf
);

    localparam int                CNT_W    = $clog2(RST_PULSE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_PULSE_CYCLES - 1);

    localparam logic [2:0] CMD_MR1    = 3'b001;
    localparam logic [2:0] CMD_RXRST  = 3'b010;
    localparam logic [2:0] CMD_TXRST  = 3'b011;
    localparam logic [2:0] CMD_ERRRST = 3'b100;
    localparam logic [2:0] CMD_BCLR   = 3'b101;
`ifdef DUART_BREAK_CTRL_EN
    localparam logic [2:0] CMD_BSTART = 3'b110;
    localparam logic [2:0] CMD_BSTOP  = 3'b111;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_RST,
        S_TX_RST,
        S_ERR_RST
`ifdef DUART_BREAK_CTRL_EN
        ,
        S_BRK_WAIT,
        S_BRK_ON
`endif
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              pend_full;
    logic [2:0]        pend_cmd;
`ifdef DUART_BREAK_CTRL_EN
    logic              err_ret_brk;   // ERR_RST returns to BRK_ON instead of IDLE
`endif

    logic       acc;
    logic [2:0] misc;
    logic       is_fsm_cmd;
    logic       tx_en_nx;
    logic       rx_en_nx;
    logic       resting;
    logic       launch_vld;
    logic [2:0] launch_cmd;
    logic       store;
    logic       drop;
    logic       wait_stop;
    logic       unused_bits;

    // Bit 7 of the command byte carries no function; TxEMT is only consulted
    // by the break states.
    assign unused_bits = ^{bus.data[7], TxEMT};

`ifdef DUART_BREAK_CTRL_EN
    assign resting = (state == S_IDLE) || (state == S_BRK_ON);
`else
    assign resting = (state == S_IDLE);
    assign BreakOut = 1'b0;
`endif

    assign busy = ~resting | pend_full;

    // Write decode: enables (disable wins), and which cmds need the sequencer.
    always_comb begin
        acc        = bus.cra_cs & ~bus.r_w;
        misc       = bus.data[6:4];
        is_fsm_cmd = 1'b0;
        tx_en_nx   = TxEN;
        rx_en_nx   = RxEN;
        if (acc) begin
            case (misc)
                CMD_RXRST, CMD_TXRST, CMD_ERRRST: is_fsm_cmd = 1'b1;
`ifdef DUART_BREAK_CTRL_EN
                CMD_BSTART, CMD_BSTOP:            is_fsm_cmd = 1'b1;
`endif
                default:                          is_fsm_cmd = 1'b0;
            endcase
            if (bus.data[3])      tx_en_nx = 1'b0;
            else if (bus.data[2]) tx_en_nx = 1'b1;
            if (bus.data[1])      rx_en_nx = 1'b0;
            else if (bus.data[0]) rx_en_nx = 1'b1;
        end
    end

    // Dispatch: a resting sequencer drains the pending slot first (the new
    // command then takes the freed slot); a working sequencer parks the new
    // command or drops it. BrkStop aborts BRK_WAIT directly since that wait
    // may never end.
    always_comb begin
        launch_vld = 1'b0;
        launch_cmd = misc;
        store      = 1'b0;
        drop       = 1'b0;
        wait_stop  = 1'b0;
        if (resting) begin
            if (pend_full) begin
                launch_vld = 1'b1;
                launch_cmd = pend_cmd;
                store      = is_fsm_cmd;
            end else if (is_fsm_cmd) begin
                launch_vld = 1'b1;
            end
        end else if (is_fsm_cmd) begin
`ifdef DUART_BREAK_CTRL_EN
            if (state == S_BRK_WAIT && misc == CMD_BSTOP) wait_stop = 1'b1;
            else
`endif
            if (pend_full) drop  = 1'b1;
            else           store = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pend_full   <= 1'b0;
            pend_cmd    <= 3'b000;
            TxEN        <= 1'b0;
            RxEN        <= 1'b0;
            RxReset_n   <= 1'b1;
            TxReset_n   <= 1'b1;
            ErrReset_n  <= 1'b1;
            mr_ptr      <= 1'b0;
            brk_chg_clr <= 1'b0;
            cmd_ovf     <= 1'b0;
`ifdef DUART_BREAK_CTRL_EN
            BreakOut    <= 1'b0;
            err_ret_brk <= 1'b0;
`endif
        end else begin
            TxEN        <= tx_en_nx;
            RxEN        <= rx_en_nx;
            brk_chg_clr <= acc && (misc == CMD_BCLR);
            cmd_ovf     <= drop;

            // cmd 001 beats a simultaneous MR write
            if (acc && misc == CMD_MR1) mr_ptr <= 1'b0;
            else if (bus.mr_wr)         mr_ptr <= 1'b1;

            if (store) begin
                pend_full <= 1'b1;
                pend_cmd  <= misc;
            end else if (launch_vld && pend_full) begin
                pend_full <= 1'b0;
            end

            // Progress of the command in flight
            case (state)
                S_RX_RST, S_TX_RST, S_ERR_RST: begin
                    if (cnt == '0) begin
                        RxReset_n  <= 1'b1;
                        TxReset_n  <= 1'b1;
                        ErrReset_n <= 1'b1;
`ifdef DUART_BREAK_CTRL_EN
                        state <= (state == S_ERR_RST && err_ret_brk) ? S_BRK_ON : S_IDLE;
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef DUART_BREAK_CTRL_EN
                S_BRK_WAIT: begin
                    if (wait_stop) begin
                        state <= S_IDLE;
                    end else if (TxEMT) begin
                        BreakOut <= 1'b1;
                        state    <= S_BRK_ON;
                    end
                end
`endif
                default: ;
            endcase

            // Start of a new command (only ever from a resting state); later
            // assignments override the plain enable update above.
            if (launch_vld) begin
                case (launch_cmd)
                    CMD_RXRST: begin
                        state     <= S_RX_RST;
                        cnt       <= CNT_LOAD;
                        RxReset_n <= 1'b0;
                        RxEN      <= 1'b0;
                    end
                    CMD_TXRST: begin
                        state     <= S_TX_RST;
                        cnt       <= CNT_LOAD;
                        TxReset_n <= 1'b0;
                        TxEN      <= 1'b0;
`ifdef DUART_BREAK_CTRL_EN
                        BreakOut  <= 1'b0;
`endif
                    end
                    CMD_ERRRST: begin
                        state      <= S_ERR_RST;
                        cnt        <= CNT_LOAD;
                        ErrReset_n <= 1'b0;
`ifdef DUART_BREAK_CTRL_EN
                        err_ret_brk <= (state == S_BRK_ON);
`endif
                    end
`ifdef DUART_BREAK_CTRL_EN
                    CMD_BSTART: begin
                        if (state != S_BRK_ON && tx_en_nx) state <= S_BRK_WAIT;
                    end
                    CMD_BSTOP: begin
                        if (state == S_BRK_ON) begin
                            BreakOut <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_duart_chan_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_duart_chan_cmd_ctrl
// Self-checking bench: directed scenarios followed by randomized CPU traffic,
// all outputs compared every cycle against a behavioural model built from
// jobs, a remaining-cycle count and a one-entry command queue.
// -----------------------------------------------------------------------------
module tb_duart_chan_cmd_ctrl;

    localparam int N = 4;
`ifdef DUART_BREAK_CTRL_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    localparam int J_NONE = 0, J_RX = 1, J_TX = 2, J_ERR = 3, J_WAIT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic TxEMT = 1'b0;
    logic TxEN, RxEN, RxReset_n, TxReset_n, ErrReset_n, mr_ptr;
    logic BreakOut, brk_chg_clr, busy, cmd_ovf;

    duart_chan_cmd_ctrl_if bus ();

    duart_chan_cmd_ctrl #(.RST_PULSE_CYCLES(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .TxEMT      (TxEMT),
        .TxEN       (TxEN),
        .RxEN       (RxEN),
        .RxReset_n  (RxReset_n),
        .TxReset_n  (TxReset_n),
        .ErrReset_n (ErrReset_n),
        .mr_ptr     (mr_ptr),
        .BreakOut   (BreakOut),
        .brk_chg_clr(brk_chg_clr),
        .busy       (busy),
        .cmd_ovf    (cmd_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_tx, m_rx, m_rxr, m_txr, m_errr, m_ptr, m_brk, m_brk_state, m_clr, m_ovf;
    int m_job, m_left;
    int q[$];

    task automatic model_reset();
        m_tx = 0; m_rx = 0; m_rxr = 1; m_txr = 1; m_errr = 1; m_ptr = 0;
        m_brk = 0; m_brk_state = 0; m_clr = 0; m_ovf = 0;
        m_job = J_NONE; m_left = 0;
        q.delete();
    endtask

    task automatic model_step(input logic cs, input logic rw, input logic [7:0] d,
                              input logic mrw, input logic emt);
        bit acc, fsm_cmd, ntx, nrx, have, stop_wait;
        int m, lc;
        acc = cs && !rw;
        m   = int'(d[6:4]);
        ntx = m_tx;
        nrx = m_rx;
        if (acc) begin
            if (d[3]) ntx = 0; else if (d[2]) ntx = 1;
            if (d[1]) nrx = 0; else if (d[0]) nrx = 1;
        end
        m_clr = acc && (m == 5);
        m_ovf = 0;
        if (acc && m == 1) m_ptr = 0;
        else if (mrw)      m_ptr = 1;
        fsm_cmd = acc && (m == 2 || m == 3 || m == 4 || (BRK && (m == 6 || m == 7)));

        have = 0; lc = 0; stop_wait = 0;
        if (m_job == J_NONE) begin
            if (q.size() > 0) begin
                lc = q.pop_front(); have = 1;
                if (fsm_cmd) q.push_back(m);
            end else if (fsm_cmd) begin
                lc = m; have = 1;
            end
        end else if (fsm_cmd) begin
            if (m_job == J_WAIT && m == 7) stop_wait = 1;
            else if (q.size() >= 1)        m_ovf = 1;
            else                           q.push_back(m);
        end

        case (m_job)
            J_RX, J_TX, J_ERR: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_job == J_RX)  m_rxr  = 1;
                    if (m_job == J_TX)  m_txr  = 1;
                    if (m_job == J_ERR) m_errr = 1;
                    m_job = J_NONE;
                end
            end
            J_WAIT: begin
                if (stop_wait) m_job = J_NONE;
                else if (emt) begin m_brk = 1; m_brk_state = 1; m_job = J_NONE; end
            end
            default: ;
        endcase

        if (have) begin
            case (lc)
                2: begin m_job = J_RX; m_left = N; m_rxr = 0; nrx = 0; m_brk_state = 0; end
                3: begin m_job = J_TX; m_left = N; m_txr = 0; ntx = 0; m_brk = 0; m_brk_state = 0; end
                4: begin m_job = J_ERR; m_left = N; m_errr = 0; end
                6: if (!m_brk_state && ntx) m_job = J_WAIT;
                7: if (m_brk_state) begin m_brk_state = 0; m_brk = 0; end
                default: ;
            endcase
        end
        m_tx = ntx;
        m_rx = nrx;
    endtask

    task automatic compare_all(input string pfx);
        check_val({pfx, ".TxEN"},        TxEN,        m_tx);
        check_val({pfx, ".RxEN"},        RxEN,        m_rx);
        check_val({pfx, ".RxReset_n"},   RxReset_n,   m_rxr);
        check_val({pfx, ".TxReset_n"},   TxReset_n,   m_txr);
        check_val({pfx, ".ErrReset_n"},  ErrReset_n,  m_errr);
        check_val({pfx, ".mr_ptr"},      mr_ptr,      m_ptr);
        check_val({pfx, ".BreakOut"},    BreakOut,    m_brk);
        check_val({pfx, ".brk_chg_clr"}, brk_chg_clr, m_clr);
        check_val({pfx, ".busy"},        busy,        (m_job != J_NONE) || (q.size() != 0));
        check_val({pfx, ".cmd_ovf"},     cmd_ovf,     m_ovf);
    endtask

    // Starts and ends at a falling edge.
    task automatic cyc(input logic cs, input logic rw, input logic [7:0] d,
                       input logic mrw, input logic emt);
        bus.cra_cs = cs; bus.r_w = rw; bus.data = d; bus.mr_wr = mrw; TxEMT = emt;
        @(posedge clk);
        model_step(cs, rw, d, mrw, emt);
        #1;
        compare_all("cyc");
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d, input logic emt);
        cyc(1'b1, 1'b0, d, 1'b0, emt);
    endtask

    task automatic idle(input logic emt);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, emt);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic reset_mid();
        #1;
        reset_n = 1'b0;
        bus.cra_cs = 1'b0; bus.r_w = 1'b1; bus.data = 8'h00; bus.mr_wr = 1'b0; TxEMT = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx_low, tx_low, ovf_seen, busy_gap;
        bus.cra_cs = 1'b0; bus.r_w = 1'b1; bus.data = 8'h00; bus.mr_wr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Enables
        wr(8'h05, 1'b0);
        check_val("en_both_tx", TxEN, 1);
        check_val("en_both_rx", RxEN, 1);
        wr(8'h0A, 1'b0);
        check_val("dis_both_tx", TxEN, 0);
        check_val("dis_both_rx", RxEN, 0);
        wr(8'h04, 1'b0);
        wr(8'h0C, 1'b0);
        check_val("dis_beats_en", TxEN, 0);

        // Rx reset pulse, queued Tx reset, dropped Err reset
        rx_low = 0; tx_low = 0; ovf_seen = 0; busy_gap = 0;
        wr(8'h01, 1'b0);
        wr(8'h20, 1'b0);
        if (!RxReset_n) rx_low++;
        wr(8'h30, 1'b0);
        if (!RxReset_n) rx_low++;
        if (!RxReset_n && !busy) busy_gap++;
        wr(8'h40, 1'b0);
        if (!RxReset_n) rx_low++;
        if (cmd_ovf) ovf_seen++;
        for (int i = 0; i < 12; i++) begin
            idle(1'b0);
            if (!RxReset_n) rx_low++;
            if (!TxReset_n) tx_low++;
            if (cmd_ovf) ovf_seen++;
            if ((!RxReset_n || !TxReset_n) && !busy) busy_gap++;
        end
        check_val("rx_low_cycles", rx_low, N);
        check_val("tx_low_cycles", tx_low, N);
        check_val("ovf_pulses", ovf_seen, 1);
        check_val("busy_gap", busy_gap, 0);
        check_val("rxen_after_rst", RxEN, 0);

`ifdef DUART_BREAK_CTRL_EN
        // Break wait on TxEMT, then stop
        wr(8'h04, 1'b0);
        wr(8'h60, 1'b0);
        repeat (3) idle(1'b0);
        check_val("brk_wait_low", BreakOut, 0);
        idle(1'b1);
        check_val("brk_on", BreakOut, 1);
        wr(8'h70, 1'b1);
        check_val("brk_off", BreakOut, 0);
        check_val("brk_off_busy", busy, 0);
`else
        // Break commands inert in this build
        wr(8'h64, 1'b1);
        check_val("nobrk_txen", TxEN, 1);
        check_val("nobrk_out", BreakOut, 0);
        check_val("nobrk_busy", busy, 0);
`endif

        // MR pointer and break-change clear
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        check_val("mr_ptr_set", mr_ptr, 1);
        cyc(1'b1, 1'b0, 8'h10, 1'b1, 1'b0);
        check_val("mr_ptr_cmd_wins", mr_ptr, 0);
        wr(8'h50, 1'b0);
        check_val("bclr_pulse", brk_chg_clr, 1);
        idle(1'b0);
        check_val("bclr_single", brk_chg_clr, 0);

        // Async reset during the second cycle of a Tx reset
        wr(8'h04, 1'b0);
        wr(8'h30, 1'b0);
        idle(1'b0);
        check_val("txrst_mid_low", TxReset_n, 0);
        reset_mid();
        check_val("rst_txreset_n", TxReset_n, 1);
        check_val("rst_busy", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic cs, rw, mrw, emt;
            logic [7:0] d;
            cs   = ($urandom_range(0, 99) < 35);
            rw   = ($urandom_range(0, 99) < 15);
            d    = 8'($urandom);
            d[3] = ($urandom_range(0, 3) == 0);
            d[2] = ($urandom_range(0, 2) == 0);
            d[1] = ($urandom_range(0, 3) == 0);
            d[0] = ($urandom_range(0, 2) == 0);
            mrw  = ($urandom_range(0, 9) == 0);
            emt  = ($urandom_range(0, 99) < 30);
            cyc(cs, rw, d, mrw, emt);
            if (i == 1000 || $urandom_range(0, 499) == 0) reset_mid();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
